// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, instruction
// field positions and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b010101;
    localparam logic [5:0] OP_JR    = 6'b010110;
    localparam logic [5:0] OP_JAL   = 6'b010111;
    localparam logic [5:0] OP_BEQ   = 6'b001010;
    localparam logic [5:0] OP_BNEQ  = 6'b001011;
    localparam logic [5:0] OP_BGEZ  = 6'b001100;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int JTGT_HI = 25;
    localparam int JTGT_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    function automatic logic is_redirect_op(input logic [5:0] opc);
        return (opc == OP_J) || (opc == OP_JR) || (opc == OP_JAL) ||
               (opc == OP_BEQ) || (opc == OP_BNEQ) || (opc == OP_BGEZ);
    endfunction

    function automatic logic is_rtype_op(input logic [5:0] opc);
        return opc == OP_RTYPE;
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: priority mux over JR, J/JAL, taken branch and
// sequential fall-through, plus a misaligned-JR-target flag.
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    input  logic        jump_i,
    input  logic        branch_i,
    input  logic        branch_cond_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic        is_jr;
    logic [31:0] imm_ext;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign is_jr      = jump_i && (instr_i[OPC_HI:OPC_LO] == OP_JR);
    assign imm_ext    = {{14{instr_i[IMM_HI]}}, instr_i[IMM_HI:IMM_LO], 2'b00};
    assign branch_tgt = pc_plus4_i + imm_ext;
    assign jump_tgt   = {pc_plus4_i[31:28], instr_i[JTGT_HI:JTGT_LO], 2'b00};

    // Only a register target can be misaligned; it is loaded word-aligned.
    always_comb begin
        next_pc_o  = pc_plus4_i;
        misalign_o = 1'b0;
        if (is_jr) begin
            next_pc_o  = {rs_data_i[31:2], 2'b00};
            misalign_o = (rs_data_i[1:0] != 2'b00);
        end else if (jump_i) begin
            next_pc_o = jump_tgt;
        end else if (branch_i && branch_cond_i) begin
            next_pc_o = branch_tgt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, handshakes with instruction memory
// and presents the captured instruction to the control decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic        branch,
    input  logic        branch_cond,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int             CW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT_CYC - 1);

    state_e        state_q;
    logic [31:0]   pc_q;
    logic [31:0]   addr_q;
    logic [31:0]   instr_q;
    logic          valid_q;
    logic          req_q;
    logic          misalign_q;
    logic          timeout_q;
    logic [CW-1:0] cnt_q;

    logic [31:0]   pc_plus4_w;
    logic [31:0]   next_pc_d;
    logic          misalign_d;

    assign pc_plus4_w = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4_i    (pc_plus4_w),
        .instr_i       (instr_q),
        .jump_i        (jump),
        .branch_i      (branch),
        .branch_cond_i (branch_cond),
        .rs_data_i     (rs_data),
        .next_pc_o     (next_pc_d),
        .misalign_o    (misalign_d)
    );

    // The wait counter saturates at the limit; timeout only flags, never aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ISSUE;
                    end else begin
                        if (cnt_q < CNT_LIMIT) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (cnt_q >= CNT_LAST) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_q    <= next_pc_d;
                        addr_q  <= next_pc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                        if (misalign_d) begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[OPC_HI:OPC_LO];
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_w;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, branch, jump, JR
// misalignment, stall and memory-timeout scenarios with hand-computed values.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        jump;
    logic        branch;
    logic        branch_cond;
    logic [31:0] rs_data;
    logic        stall;
    logic        misalign_err;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .jump         (jump),
        .branch       (branch),
        .branch_cond  (branch_cond),
        .rs_data      (rs_data),
        .stall        (stall),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one instruction word for a single edge; expects a request pending.
    task automatic fetchWord(input logic [31:0] word);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_req: imem_req=%b required 1", imem_req);
        end
        imem_rdata = word;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic issueStep(input logic j, input logic b, input logic c, input logic [31:0] rs);
        jump        = j;
        branch      = b;
        branch_cond = c;
        rs_data     = rs;
        @(negedge clk);
        jump        = 1'b0;
        branch      = 1'b0;
        branch_cond = 1'b0;
        rs_data     = 32'h0;
    endtask

    task automatic jumpTo(input logic [31:0] target);
        fetchWord({OP_JR, 26'h0});
        issueStep(1'b1, 1'b0, 1'b0, target);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, misalign_err, timeout_err} !== 4'b0000 ||
            imem_addr !== 32'h0 || pc !== 32'h0 || instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: req=%b valid=%b mis=%b to=%b addr=%h pc=%h instr=%h required all zero",
                     imem_req, instr_valid, misalign_err, timeout_err, imem_addr, pc, instr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_req: req=%b addr=%h valid=%b required 1/00000000/0",
                     imem_req, imem_addr, instr_valid);
        end
        @(negedge clk);
        imem_rdata = 32'h0;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_issue: valid=%b pc=%h instr=%h req=%b required 1/00000000/00000000/0",
                     instr_valid, pc, instr, imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_addr: addr=%h req=%b valid=%b required 00000004/1/0",
                     imem_addr, imem_req, instr_valid);
        end
    endtask

    task automatic test_branch;
        jumpTo(32'h0000_0100);
        fetchWord({OP_BEQ, 10'h0, 16'hFFFE});
        checks++;
        if (opcode !== OP_BEQ || pc_plus4 !== 32'h0000_0104) begin
            errors++;
            $display("[TB] FAIL branch_issue: opcode=%b pc_plus4=%h required 001010/00000104", opcode, pc_plus4);
        end
        issueStep(1'b0, 1'b1, 1'b1, 32'h0);
        checks++;
        if (imem_addr !== 32'h0000_00FC || pc !== 32'h0000_00FC) begin
            errors++;
            $display("[TB] FAIL branch_taken: addr=%h pc=%h required 000000fc", imem_addr, pc);
        end
        jumpTo(32'h0000_0100);
        fetchWord({OP_BEQ, 10'h0, 16'hFFFE});
        issueStep(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h0000_0104) begin
            errors++;
            $display("[TB] FAIL branch_not_taken: addr=%h required 00000104", imem_addr);
        end
    endtask

    task automatic test_jump;
        jumpTo(32'h1000_0000);
        fetchWord({OP_J, 26'h0000040});
        issueStep(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h1000_0100 || pc !== 32'h1000_0100) begin
            errors++;
            $display("[TB] FAIL jump_target: addr=%h pc=%h required 10000100", imem_addr, pc);
        end
        jumpTo(32'h1000_0000);
        fetchWord({OP_JAL, 26'h0000040});
        checks++;
        if (pc_plus4 !== 32'h1000_0004) begin
            errors++;
            $display("[TB] FAIL jal_link: pc_plus4=%h required 10000004", pc_plus4);
        end
        issueStep(1'b1, 1'b1, 1'b1, 32'h0);
        checks++;
        if (imem_addr !== 32'h1000_0100) begin
            errors++;
            $display("[TB] FAIL jump_over_branch: addr=%h required 10000100", imem_addr);
        end
        jumpTo(32'hFFFF_FFFC);
        fetchWord({OP_RTYPE, 26'h0});
        checks++;
        if (pc_plus4 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL pc_wrap: pc_plus4=%h required 00000000", pc_plus4);
        end
        issueStep(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_addr: addr=%h mis=%b required 00000000/0", imem_addr, misalign_err);
        end
    endtask

    task automatic test_misalign;
        jumpTo(32'h0000_2003);
        checks++;
        if (imem_addr !== 32'h0000_2000 || pc !== 32'h0000_2000 || misalign_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jr_misalign: addr=%h pc=%h mis=%b required 00002000/00002000/1",
                     imem_addr, pc, misalign_err);
        end
        for (int i = 0; i < 10; i++) begin
            fetchWord({OP_RTYPE, 26'h0});
            issueStep(1'b0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (misalign_err !== 1'b1) begin
                errors++;
                $display("[TB] FAIL misalign_sticky: iter=%0d mis=%b required 1", i, misalign_err);
            end
        end
        checks++;
        if (imem_addr !== 32'h0000_2028) begin
            errors++;
            $display("[TB] FAIL seq_after_jr: addr=%h required 00002028", imem_addr);
        end
    endtask

    task automatic test_stall;
        fetchWord(32'h0123_4567);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr !== 32'h0123_4567 || pc !== 32'h0000_2028 ||
                instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: cyc=%0d instr=%h pc=%h valid=%b req=%b required 01234567/00002028/1/0",
                         i, instr, pc, instr_valid, imem_req);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h0000_202C || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: addr=%h req=%b valid=%b required 0000202c/1/0",
                     imem_addr, imem_req, instr_valid);
        end
    endtask

    task automatic test_timeout;
        jump    = 1'b1;
        rs_data = 32'h0000_8000;
        repeat (15) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early: to=%b required 0 after 15 waits", timeout_err);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || imem_addr !== 32'h0000_202C || imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_set: to=%b addr=%h req=%b required 1/0000202c/1",
                     timeout_err, imem_addr, imem_req);
        end
        jump    = 1'b0;
        rs_data = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (misalign_err !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flags_before_reset: mis=%b to=%b required 1/1", misalign_err, timeout_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || misalign_err !== 1'b0 || timeout_err !== 1'b0 ||
            instr_valid !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: req=%b mis=%b to=%b valid=%b addr=%h pc=%h required all zero",
                     imem_req, misalign_err, timeout_err, instr_valid, imem_addr, pc);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_ready: valid=%b instr=%h req=%b required 0/00000000/0",
                     instr_valid, instr, imem_req);
        end
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        rst_n      = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL restart: req=%b valid=%b addr=%h required 1/0/00000000",
                     imem_req, instr_valid, imem_addr);
        end
    endtask

    initial begin
        imem_rdata  = 32'h0;
        imem_ready  = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        branch_cond = 1'b0;
        rs_data     = 32'h0;
        stall       = 1'b0;
        test_reset();
        test_branch();
        test_jump();
        test_misalign();
        test_stall();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
